// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - shared widths and ALU select codes for the issue stage
package alu_issue_stage_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_NUM_REGS   = 2 ** DEF_REG_ADDR_W;
  localparam int SEL_W          = 4;

  typedef enum logic [SEL_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_EQ  = 4'd5,
    ALU_GT  = 4'd6,
    ALU_LT  = 4'd7,
    ALU_SHR = 4'd8,
    ALU_SHL = 4'd9
  } alu_sel_e;

endpackage

// File: rtl/alu_issue_stage_reg_file_2r1w.sv
// rtl/alu_issue_stage_reg_file_2r1w.sv - register file, 2 async reads, 1 sync write, r0 reads 0
module alu_issue_stage_reg_file_2r1w
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_REG_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [ADDR_W-1:0] rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Reset has priority, so a write pending on the reset edge is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operand fetch/issue (EX) and result capture (WB) around an external ALU
// ALU_ISSUE_FWD_EN: forward alu_c into the accepted op instead of stalling on a RAW hazard.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [SEL_W-1:0]      in_op_i,
  input  logic [REG_ADDR_W-1:0] in_rs_i,
  input  logic [REG_ADDR_W-1:0] in_rt_i,
  input  logic [REG_ADDR_W-1:0] in_rd_i,
  input  logic                  in_we_i,
  output logic [DATA_W-1:0]     alu_a_o,
  output logic [DATA_W-1:0]     alu_b_o,
  output logic [SEL_W-1:0]      alu_sel_o,
  input  logic [DATA_W-1:0]     alu_c_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     out_data_o,
  output logic [REG_ADDR_W-1:0] out_rd_o
);

  logic                  ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0]     ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic [SEL_W-1:0]      ex_sel_q, ex_sel_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_we_q, ex_we_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic [REG_ADDR_W-1:0] out_rd_q, out_rd_d;

  logic [DATA_W-1:0] rf_a, rf_b, opnd_a, opnd_b;
  logic advance, xfer, wb_we, in_ready, accept;

  assign advance = !out_valid_q || out_ready_i;
  assign xfer    = ex_valid_q && advance;
  assign wb_we   = xfer && ex_we_q && (ex_rd_q != '0);

  alu_issue_stage_reg_file_2r1w #(
    .DATA_W   (DATA_W),
    .ADDR_W   (REG_ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .ra_addr_i (in_rs_i),
    .ra_data_o (rf_a),
    .rb_addr_i (in_rt_i),
    .rb_data_o (rf_b),
    .we_i      (wb_we),
    .wa_i      (ex_rd_q),
    .wd_i      (alu_c_i)
  );

`ifdef ALU_ISSUE_FWD_EN
  assign opnd_a   = (wb_we && (ex_rd_q == in_rs_i)) ? alu_c_i : rf_a;
  assign opnd_b   = (wb_we && (ex_rd_q == in_rt_i)) ? alu_c_i : rf_b;
  assign in_ready = !ex_valid_q || advance;
`else
  logic raw_hazard;
  // Interlock until the producer leaves EX; the RF then holds its result.
  assign raw_hazard = ex_valid_q && ex_we_q && (ex_rd_q != '0) &&
                      ((ex_rd_q == in_rs_i) || (ex_rd_q == in_rt_i));
  assign opnd_a     = rf_a;
  assign opnd_b     = rf_b;
  assign in_ready   = (!ex_valid_q || advance) && !raw_hazard;
`endif

  assign accept = in_valid_i && in_ready;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_sel_d    = ex_sel_q;
    ex_rd_d     = ex_rd_q;
    ex_we_d     = ex_we_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;

    if (accept) begin
      ex_valid_d = 1'b1;
      ex_a_d     = opnd_a;
      ex_b_d     = opnd_b;
      ex_sel_d   = in_op_i;
      ex_rd_d    = in_rd_i;
      ex_we_d    = in_we_i;
    end else if (xfer) begin
      ex_valid_d = 1'b0;
    end

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = alu_c_i;
      out_rd_d    = ex_rd_q;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ex_valid_q  <= 1'b0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_sel_q    <= '0;
      ex_rd_q     <= '0;
      ex_we_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_sel_q    <= ex_sel_d;
      ex_rd_q     <= ex_rd_d;
      ex_we_q     <= ex_we_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign alu_a_o     = ex_a_q;
  assign alu_b_o     = ex_b_q;
  assign alu_sel_o   = ex_sel_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_rd_o    = out_rd_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with an inline ALU model
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef ALU_ISSUE_FWD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_we;
  logic [3:0]    in_op;
  logic [AW-1:0] in_rs, in_rt, in_rd;
  logic [DW-1:0] alu_a, alu_b, alu_c;
  logic [3:0]    alu_sel;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_rd;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   st;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_op_i     (in_op),
    .in_rs_i     (in_rs),
    .in_rt_i     (in_rt),
    .in_rd_i     (in_rd),
    .in_we_i     (in_we),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_sel_o   (alu_sel),
    .alu_c_i     (alu_c),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_rd_o    (out_rd)
  );

  always_comb begin
    alu_c = '0;
    case (alu_sel)
      ALU_ADD: alu_c = alu_a + alu_b;
      ALU_SUB: alu_c = alu_a - alu_b;
      ALU_AND: alu_c = alu_a & alu_b;
      ALU_OR:  alu_c = alu_a | alu_b;
      ALU_XOR: alu_c = alu_a ^ alu_b;
      ALU_EQ:  alu_c = {31'd0, alu_a == alu_b};
      ALU_GT:  alu_c = {31'd0, alu_a > alu_b};
      ALU_LT:  alu_c = {31'd0, alu_a < alu_b};
      ALU_SHR: alu_c = alu_a >> alu_b[4:0];
      ALU_SHL: alu_c = alu_a << alu_b[4:0];
      default: alu_c = '0;
    endcase
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic [AW-1:0] rd, input logic we, input logic [DW-1:0] exp_data,
                      output int stalls);
    bit   timed_out;
    exp_t e;
    in_valid  = 1'b1;
    in_op     = op;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_we     = we;
    stalls    = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, expected accept", stalls);
        timed_out = 1'b1;
        break;
      end
    end
    if (!timed_out) begin
      e.data = exp_data;
      e.rd   = rd;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got data 0x%0h rd %0d, expected no output", out_data, out_rd);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_rd", DW'(out_rd), DW'(e.rd));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_op     = ALU_ADD;
    in_rs     = 5'd1;
    in_rt     = 5'd2;
    in_rd     = 5'd3;
    in_we     = 1'b1;
    out_ready = 1'b1;

    // Reset with an op presented: nothing must be captured.
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", DW'(out_valid), 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", DW'(alu_sel), 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", DW'(in_ready), 1);

    // Latency on an empty pipe, reading cleared registers.
    @(posedge clk);
    #1;
    send(ALU_SUB, 5'd7, 5'd9, 5'd10, 1'b0, 32'd0, st);
    @(negedge clk);
    check("lat_alu_sel", DW'(alu_sel), 1);
    check("lat_wb_empty", DW'(out_valid), 0);
    @(negedge clk);
    check("lat_wb_valid", DW'(out_valid), 1);
    check("lat_wb_rd", DW'(out_rd), 10);
    idle(2);

    // Seed r1=5, r2=3 from r0 via EQ/ADD chains, then dependent ADD and SUB.
    send(ALU_EQ,  5'd0, 5'd0, 5'd2, 1'b1, 32'd1, st);
    send(ALU_ADD, 5'd2, 5'd2, 5'd1, 1'b1, 32'd2, st);
    send(ALU_ADD, 5'd1, 5'd2, 5'd2, 1'b1, 32'd3, st);
    send(ALU_ADD, 5'd1, 5'd2, 5'd1, 1'b1, 32'd5, st);
    send(ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 32'd8, st);
    send(ALU_SUB, 5'd3, 5'd1, 5'd4, 1'b1, 32'd3, st);
    check("sub_stalls", DW'(st), DW'(EXP_STALL));
    idle(3);

    // Backpressure: WB and EX both held, result frozen.
    out_ready = 1'b0;
    send(ALU_XOR, 5'd1, 5'd2, 5'd5, 1'b1, 32'd6, st);
    send(ALU_OR,  5'd1, 5'd2, 5'd6, 1'b1, 32'd7, st);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out_valid", DW'(out_valid), 1);
      check("bp_out_data", out_data, 32'd6);
      check("bp_in_ready", DW'(in_ready), 0);
      check("bp_alu_a", alu_a, 32'd5);
      check("bp_alu_sel", DW'(alu_sel), DW'(ALU_OR));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(3);
    check("bp_drained", DW'(sb.size()), 0);

    // r0 destination: result visible downstream but never stored or forwarded.
    send(ALU_ADD, 5'd1, 5'd2, 5'd0, 1'b1, 32'd8, st);
    send(ALU_ADD, 5'd0, 5'd0, 5'd7, 1'b1, 32'd0, st);
    check("r0_no_stall", DW'(st), 0);
    send(ALU_OR,  5'd0, 5'd2, 5'd8, 1'b0, 32'd3, st);
    idle(3);

    // Reset with EX and WB full: in-flight ops dropped, no write to r12.
    out_ready = 1'b0;
    send(ALU_ADD, 5'd1, 5'd2, 5'd11, 1'b1, 32'd8, st);
    send(ALU_ADD, 5'd1, 5'd1, 5'd12, 1'b1, 32'd10, st);
    sb.delete();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", DW'(out_valid), 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_in_ready", DW'(in_ready), 1);
    @(posedge clk);
    #1;
    send(ALU_ADD, 5'd11, 5'd12, 5'd13, 1'b0, 32'd0, st);
    send(ALU_OR,  5'd12, 5'd0,  5'd14, 1'b0, 32'd0, st);
    idle(4);
    check("final_drained", DW'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
